fifo_rd_drain: RTL and testbench

- Read-side consumer of the asynchronous FIFO, clocked in the read domain.
- Issues rd_en against empty and captures rdata one cycle after each accepted read.
- Re-presents the captured words as a valid/ready stream through a 2-entry output buffer, so the downstream consumer may stall without losing data.
- Provides flush, a delivered-word counter and a sticky underflow error flag.

---
 rtl/fifo_rd_drain.sv | 118 +++++++++++
 tb/tb_fifo_rd_drain.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain: read-side drain of the async FIFO, re-presenting words as a
// valid/ready stream through a 2-entry skid buffer, with flush and counters.
//
// Ports:
//   rd_clk, rst        read-domain clock, synchronous active-high reset
//   empty, underflow   FIFO status (underflow sampled in the capture cycle)
//   rdata              FIFO read data, valid one cycle after an accepted read
//   rd_en              FIFO read request
//   m_valid, m_ready   downstream handshake
//   m_data             downstream word (buffer head)
//   flush              single-cycle discard of buffered and in-flight data
//   rd_cnt             words delivered downstream (wraps)
//   err_underflow      sticky underflow error, cleared only by rst
module fifo_rd_drain #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             rd_clk,
    input  logic             rst,
    input  logic             empty,
    input  logic             underflow,
    input  logic [WIDTH-1:0] rdata,
    output logic             rd_en,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    input  logic             flush,
    output logic [CNT_W-1:0] rd_cnt,
    output logic             err_underflow
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [1:0]       occ;
    logic             inflight;
    logic [WIDTH-1:0] buf0;
    logic [WIDTH-1:0] buf1;
    logic             pop;
    logic             cap;
    logic [1:0]       occ_pop;
    logic [1:0]       owed;

    // Words held plus the one still on its way; bounded to the buffer depth.
    assign owed    = occ + {1'b0, inflight};
    assign m_valid = (occ != 2'd0);
    assign m_data  = buf0;
    assign pop     = m_valid & m_ready;
    assign occ_pop = occ - {1'b0, pop};

    // A returning word is kept only in RUN and not in the flush cycle itself.
    assign cap = inflight & ~underflow & (state == RUN) & ~flush;

    always_comb begin
        state_n = state;
        rd_en   = 1'b0;
        unique case (state)
            RUN: begin
                if (flush) begin
                    state_n = FLUSH;
                end else if (!empty && owed < 2'd2) begin
                    rd_en = 1'b1;
                end
            end
            FLUSH: begin
                if (!inflight) begin
                    state_n = RUN;
                end
            end
            default: state_n = RUN;
        endcase
        if (rst) begin
            rd_en = 1'b0;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            state         <= RUN;
            occ           <= 2'd0;
            inflight      <= 1'b0;
            rd_cnt        <= '0;
            err_underflow <= 1'b0;
            buf0          <= '0;
            buf1          <= '0;
        end else begin
            state    <= state_n;
            inflight <= rd_en & ~empty;
            if (pop) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
            if (inflight && underflow) begin
                err_underflow <= 1'b1;
            end
            if (flush) begin
                occ <= 2'd0;
            end else begin
                occ <= occ_pop + {1'b0, cap};
                if (pop) begin
                    buf0 <= buf1;
                end
                // New word lands directly behind the (possibly new) head.
                if (cap) begin
                    if (occ_pop == 2'd0) begin
                        buf0 <= rdata;
                    end else begin
                        buf1 <= rdata;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_drain.sv
// tb_fifo_rd_drain: directed bench with a FIFO model, an expected-word
// scoreboard queue and a monitor that checks every downstream handshake.
module tb_fifo_rd_drain;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          rd_clk = 1'b0;
    logic          rst;
    logic          empty;
    logic          underflow;
    logic [W-1:0]  rdata;
    logic          rd_en;
    logic          m_valid;
    logic          m_ready;
    logic [W-1:0]  m_data;
    logic          flush;
    logic [CW-1:0] rd_cnt;
    logic          err_underflow;

    fifo_rd_drain #(.WIDTH(W), .CNT_W(CW)) dut (
        .rd_clk        (rd_clk),
        .rst           (rst),
        .empty         (empty),
        .underflow     (underflow),
        .rdata         (rdata),
        .rd_en         (rd_en),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .flush         (flush),
        .rd_cnt        (rd_cnt),
        .err_underflow (err_underflow)
    );

    always #5 rd_clk = ~rd_clk;

    logic [8:0]    fifo_q[$];
    logic [W-1:0]  exp_q[$];
    logic [8:0]    e;
    logic [CW-1:0] exp_cnt = '0;
    int            issued = 0;
    int            checks = 0;
    int            passes = 0;

    function automatic void chk(string name, int act, int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    endfunction

    // FIFO model: word appears on rdata one cycle after an accepted read.
    always @(posedge rd_clk) begin
        if (rd_en && !empty) begin
            e = fifo_q.pop_front();
            rdata     <= e[7:0];
            underflow <= e[8];
            empty     <= (fifo_q.size() == 0);
        end else begin
            underflow <= 1'b0;
        end
    end

    // Monitor: counter tracking, read-legality and scoreboard compare.
    always @(negedge rd_clk) begin
        chk("rd_cnt", int'(rd_cnt), int'(exp_cnt));
        chk("rd_en_legal", int'(rd_en && (empty || rst)), 0);
        if (rd_en && !empty && !rst) issued++;
        if (rst) begin
            exp_cnt = '0;
        end else if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", int'(m_data), -1);
            end else begin
                chk("m_data", int'(m_data), int'(exp_q.pop_front()));
            end
            exp_cnt = exp_cnt + 1'b1;
        end
    end

    task automatic push(input logic [7:0] w, input bit bad, input bit keep);
        fifo_q.push_back({bad, w});
        if (keep) exp_q.push_back(w);
        empty = 1'b0;
    endtask

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic drain(input string name, input int max);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max) begin
            @(negedge rd_clk);
            n++;
        end
        chk({name, "_drain_timeout"}, int'(exp_q.size() != 0), 0);
        repeat (3) tick();
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        empty     = 1'b1;
        underflow = 1'b0;
        rdata     = '0;
        m_ready   = 1'b0;
        flush     = 1'b0;

        // Reset then idle
        repeat (2) begin
            @(negedge rd_clk);
            chk("rst_rd_en", int'(rd_en), 0);
            chk("rst_m_valid", int'(m_valid), 0);
            chk("rst_err", int'(err_underflow), 0);
        end
        tick();
        rst = 1'b0;
        repeat (2) tick();

        // Streaming
        m_ready = 1'b1;
        issued  = 0;
        push(8'h11, 0, 1);
        push(8'h22, 0, 1);
        push(8'h33, 0, 1);
        push(8'h44, 0, 1);
        drain("stream", 40);
        chk("stream_issued", issued, 4);
        chk("stream_cnt", int'(rd_cnt), 4);

        // Backpressure
        m_ready = 1'b0;
        issued  = 0;
        push(8'hA1, 0, 1);
        push(8'hA2, 0, 1);
        push(8'hA3, 0, 1);
        push(8'hA4, 0, 1);
        push(8'hA5, 0, 1);
        repeat (8) tick();
        chk("bp_issued", issued, 2);
        chk("bp_rd_en", int'(rd_en), 0);
        chk("bp_m_valid", int'(m_valid), 1);
        chk("bp_head", int'(m_data), 'hA1);
        m_ready = 1'b1;
        drain("bp", 60);
        chk("bp_issued_all", issued, 5);
        chk("bp_cnt", int'(rd_cnt), 9);

        // Flush with a word buffered and one in flight
        m_ready = 1'b0;
        push(8'hB1, 0, 0);
        push(8'hB2, 0, 0);
        push(8'hC3, 0, 1);
        push(8'hD4, 0, 1);
        n = 0;
        do begin
            @(negedge rd_clk);
            n++;
        end while (!m_valid && n < 20);
        chk("flush_wait_timeout", int'(m_valid), 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge rd_clk);
        chk("flush_m_valid", int'(m_valid), 0);
        chk("flush_rd_en", int'(rd_en), 0);
        @(negedge rd_clk);
        chk("flush_resume", int'(rd_en), 1);
        m_ready = 1'b1;
        drain("flush", 40);
        chk("flush_cnt", int'(rd_cnt), 11);

        // Underflow
        chk("uf_err_before", int'(err_underflow), 0);
        push(8'h55, 0, 1);
        push(8'hAA, 1, 0);
        push(8'h66, 0, 1);
        drain("uf", 40);
        chk("uf_err_set", int'(err_underflow), 1);
        repeat (10) tick();
        chk("uf_err_sticky", int'(err_underflow), 1);
        chk("uf_cnt", int'(rd_cnt), 13);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("uf_err_cleared", int'(err_underflow), 0);
        chk("rst_cnt", int'(rd_cnt), 0);
        chk("rst_m_valid2", int'(m_valid), 0);

        // Counter wrap with a 4-bit counter
        for (int i = 0; i < 17; i++) begin
            push(8'(8'h30 + i), 0, 1);
        end
        drain("wrap", 200);
        chk("wrap_cnt", int'(rd_cnt), 1);
        chk("wrap_idle", int'(m_valid), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
